// File: rtl/serial_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_receiver_pkg
//   Shared definitions for the serial receiver slice: receiver FSM state
//   encoding, default word length and synchroniser depth, and a helper for
//   sizing the bit counter.
// -----------------------------------------------------------------------------
package serial_receiver_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Encoding matches the transmitter side so both ends read the same in
    // waveforms.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_END = 2'd2
    } rx_state_t;

    // Counter width able to hold 0..width.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_receiver_if
//   One-entry valid/ready word output of the serial receiver.
//   RxData  : received word, bit0 = last bit received
//   RxValid : RxData holds an unread word
//   RxReady : consumer accepts RxData when RxValid && RxReady
//   master  : the receiver (drives RxData/RxValid)
//   slave   : the consumer (drives RxReady)
// -----------------------------------------------------------------------------
interface serial_receiver_if
    import serial_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] RxData;
    logic             RxValid;
    logic             RxReady;

    modport master (
        output RxData,
        output RxValid,
        input  RxReady
    );

    modport slave (
        input  RxData,
        input  RxValid,
        output RxReady
    );

endinterface

// File: rtl/serial_receiver_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Single-bit multi-flop synchroniser into the Clk domain.
//   Clk   : destination clock
//   Reset : asynchronous, active-high; clears every stage to 0
//   d     : asynchronous input bit
//   q     : synchronised output, STAGES Clk edges behind d
// -----------------------------------------------------------------------------
module sync_ff
    import serial_receiver_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//   Deserialises the MSB-first bit stream on SerIn into WIDTH-bit words and
//   presents each word on a one-entry valid/ready buffer. Reports dropped
//   words (sticky Overrun) and frames that end early (FrameErr pulse).
//
//   Ports
//   Clk      : system clock
//   Reset    : asynchronous, active-high reset
//   SerIn    : serial data, asynchronous to Clk
//   SerFrame : high while a word is on the line, asynchronous to Clk
//   BitTick  : one-Clk pulse at each bit's sample point (Clk domain)
//   ClrErr   : clears Overrun (a simultaneous set wins)
//   rx       : word output (RxData / RxValid / RxReady)
//   RxBusy   : high while a word is being shifted in
//   Overrun  : sticky, a completed word was dropped
//   FrameErr : one-cycle pulse, frame ended before WIDTH bits
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for a rising edge on the synchronised frame signal
//   SHIFT    | sampling one bit per BitTick until WIDTH bits are in
//   WAIT_END | word done; ticks ignored until the frame signal drops
// -----------------------------------------------------------------------------
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SerIn,
    input  logic              SerFrame,
    input  logic              BitTick,
    input  logic              ClrErr,
    serial_receiver_if.master rx,
    output logic              RxBusy,
    output logic              Overrun,
    output logic              FrameErr
);

    localparam int             CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;

    logic             din_s;
    logic             frm_s;
    logic             frm_q;
    logic             frm_rise;

    logic [CW-1:0]    cnt;
    // Holds the WIDTH-1 bits received so far; the final bit is taken
    // straight from the synchroniser so the word is ready on the last tick.
    logic [WIDTH-2:0] sh;
    logic [WIDTH-1:0] word_in;

    logic             do_start;
    logic             do_shift;
    logic             do_complete;
    logic             do_abort;
    logic             load_word;
    logic             drop_word;

    // ---------------------------------------------------------------- sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_din (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (SerIn),
        .q     (din_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_frm (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (SerFrame),
        .q     (frm_s)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frm_q <= 1'b0;
        end else begin
            frm_q <= frm_s;
        end
    end

    assign frm_rise = frm_s & ~frm_q;

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        do_start    = 1'b0;
        do_shift    = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;

        case (state)
            IDLE: begin
                if (frm_rise) begin
                    do_start  = 1'b1;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                // The completing tick beats a frame drop seen in the same cycle.
                if (BitTick && (cnt == LAST)) begin
                    do_complete = 1'b1;
                    state_nxt   = WAIT_END;
                end else if (!frm_s) begin
                    do_abort  = 1'b1;
                    state_nxt = IDLE;
                end else if (BitTick) begin
                    do_shift = 1'b1;
                end
            end

            WAIT_END: begin
                if (!frm_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign RxBusy = (state == SHIFT);

    // ------------------------------------------------ shift register/count
    assign word_in = {sh, din_s};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            sh  <= '0;
        end else if (do_start || do_complete || do_abort) begin
            // Counter parks at 0 outside SHIFT so it never passes WIDTH-1.
            cnt <= '0;
            sh  <= '0;
        end else if (do_shift) begin
            cnt <= cnt + 1'b1;
            sh  <= word_in[WIDTH-2:0];
        end
    end

    // ------------------------------------------------------- output buffer
    // A pending word is replaced only when it is being consumed this cycle.
    assign load_word = do_complete && (!rx.RxValid || rx.RxReady);
    assign drop_word = do_complete &&   rx.RxValid && !rx.RxReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx.RxData  <= '0;
            rx.RxValid <= 1'b0;
        end else if (load_word) begin
            rx.RxData  <= word_in;
            rx.RxValid <= 1'b1;
        end else if (rx.RxValid && rx.RxReady) begin
            rx.RxValid <= 1'b0;
        end
    end

    // --------------------------------------------------------- error flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Overrun  <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            FrameErr <= do_abort;
            if (drop_word) begin
                Overrun <= 1'b1;
            end else if (ClrErr) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
module tb_serial_receiver;
    import serial_receiver_pkg::*;

    localparam int W = 32;

    logic Clk = 1'b0;
    logic Reset;
    logic SerIn;
    logic SerFrame;
    logic BitTick;
    logic ClrErr;
    logic rx_ready;
    logic RxBusy;
    logic Overrun;
    logic FrameErr;

    serial_receiver_if #(.WIDTH(W)) rx_if ();
    assign rx_if.RxReady = rx_ready;

    serial_receiver #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .SerIn    (SerIn),
        .SerFrame (SerFrame),
        .BitTick  (BitTick),
        .ClrErr   (ClrErr),
        .rx       (rx_if),
        .RxBusy   (RxBusy),
        .Overrun  (Overrun),
        .FrameErr (FrameErr)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int fe_cnt = 0;

    // Counts cycles with FrameErr high: a correct one-cycle pulse adds 1.
    always @(negedge Clk) if (FrameErr === 1'b1) fe_cnt++;

    // Reference model of the output buffer, built from the word-level rules.
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovr;
    int           m_fe;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          extra;
        logic        rdy_last;
        logic        clr_last;
        logic        lat_chk;
        logic        read_after;
        logic        clr_after;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic        exp_ovr;
        int          exp_fe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int nbits, input int extra,
                              input logic rdy_last, input logic clr_last, input logic lat_chk);
        SerFrame = 1'b1;
        SerIn    = 1'b0;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < nbits; i++) begin
            SerIn = w[W-1-i];
            repeat (3) @(negedge Clk);
            if (i == W-1) begin
                if (lat_chk) chk("rxvalid_before_last_tick", rx_if.RxValid, 0);
                rx_ready = rdy_last;
                ClrErr   = clr_last;
            end
            BitTick = 1'b1;
            @(negedge Clk);
            BitTick  = 1'b0;
            rx_ready = 1'b0;
            ClrErr   = 1'b0;
            if (i == 0) chk("rxbusy_in_frame", RxBusy, 1);
            if (i == W-1 && lat_chk) chk("rxvalid_after_last_tick", rx_if.RxValid, 1);
        end
        for (int i = 0; i < extra; i++) begin
            SerIn = 1'($urandom_range(0, 1));
            repeat (3) @(negedge Clk);
            BitTick = 1'b1;
            @(negedge Clk);
            BitTick = 1'b0;
        end
        SerFrame = 1'b0;
        SerIn    = 1'b0;
        repeat (6) @(negedge Clk);
        chk("rxbusy_after_frame", RxBusy, 0);
    endtask

    task automatic pulse_read();
        rx_ready = 1'b1;
        @(negedge Clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        ClrErr = 1'b1;
        @(negedge Clk);
        ClrErr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        Reset    = 1'b1;
        SerIn    = 1'b0;
        SerFrame = 1'b0;
        BitTick  = 1'b0;
        ClrErr   = 1'b0;
        rx_ready = 1'b0;

        //        word          nb  ex rdy clr lat rd  cl  exp_data      v  ov fe
        vecs[0] = '{32'hA5C3_0F81, 32, 0, 0, 0, 1, 0, 0, 32'hA5C3_0F81, 1, 0, 0};
        vecs[1] = '{32'h1234_5678, 32, 0, 0, 0, 0, 1, 1, 32'hA5C3_0F81, 1, 1, 0};
        vecs[2] = '{32'hFFFF_0000, 10, 0, 0, 0, 0, 0, 0, 32'hA5C3_0F81, 0, 0, 1};
        vecs[3] = '{32'h0000_0001, 32, 0, 0, 0, 1, 0, 0, 32'h0000_0001, 1, 0, 1};
        vecs[4] = '{32'hDEAD_BEEF, 32, 0, 1, 0, 0, 1, 0, 32'hDEAD_BEEF, 1, 0, 1};
        vecs[5] = '{32'h0F0F_1234, 32, 8, 0, 0, 1, 1, 0, 32'h0F0F_1234, 1, 0, 1};
        vecs[6] = '{32'h8000_0000, 31, 0, 0, 0, 0, 0, 0, 32'h0F0F_1234, 0, 0, 2};
        vecs[7] = '{32'hFFFF_FFFF, 32, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 2};
        vecs[8] = '{32'h1111_2222, 32, 0, 0, 1, 0, 1, 1, 32'hFFFF_FFFF, 1, 1, 2};
        vecs[9] = '{32'h3333_4444, 32, 0, 0, 0, 1, 0, 0, 32'h3333_4444, 1, 0, 2};

        repeat (3) @(negedge Clk);
        chk("reset_rxvalid",  rx_if.RxValid, 0);
        chk("reset_rxdata",   rx_if.RxData, 0);
        chk("reset_rxbusy",   RxBusy, 0);
        chk("reset_overrun",  Overrun, 0);
        chk("reset_frameerr", FrameErr, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // ------------------------------------------------ directed table
        for (int k = 0; k < 10; k++) begin
            send_frame(vecs[k].word, vecs[k].nbits, vecs[k].extra,
                       vecs[k].rdy_last, vecs[k].clr_last, vecs[k].lat_chk);
            chk($sformatf("vec%0d_data", k),  rx_if.RxData,  vecs[k].exp_data);
            chk($sformatf("vec%0d_valid", k), rx_if.RxValid, vecs[k].exp_valid);
            chk($sformatf("vec%0d_ovr", k),   Overrun,       vecs[k].exp_ovr);
            chk($sformatf("vec%0d_fe", k),    fe_cnt,        vecs[k].exp_fe);
            if (vecs[k].read_after) pulse_read();
            if (vecs[k].clr_after)  pulse_clr();
        end

        // ------------------------------------- reset in the middle of a word
        SerFrame = 1'b1;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < 16; i++) begin
            SerIn = 1'($urandom_range(0, 1));
            repeat (3) @(negedge Clk);
            BitTick = 1'b1;
            @(negedge Clk);
            BitTick = 1'b0;
        end
        Reset = 1'b1;
        #1;
        chk("midreset_rxvalid", rx_if.RxValid, 0);
        chk("midreset_rxdata",  rx_if.RxData, 0);
        chk("midreset_rxbusy",  RxBusy, 0);
        chk("midreset_overrun", Overrun, 0);
        SerFrame = 1'b0;
        SerIn    = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        send_frame(32'hC0FF_EE11, 32, 0, 0, 0, 1);
        chk("postreset_data",  rx_if.RxData, 32'hC0FF_EE11);
        chk("postreset_valid", rx_if.RxValid, 1);
        chk("postreset_fe",    fe_cnt, 2);

        // ------------------------------------------- randomized vs. model
        do_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 2;
        for (int it = 0; it < 30; it++) begin
            logic [W-1:0] w;
            logic         trunc, rdy, clr;
            int           nb, ex;
            w     = $urandom;
            trunc = ($urandom_range(0, 3) == 0);
            nb    = trunc ? int'($urandom_range(1, W-1)) : W;
            ex    = trunc ? 0 : int'($urandom_range(0, 4));
            rdy   = 1'($urandom_range(0, 1));
            clr   = 1'($urandom_range(0, 1));
            send_frame(w, nb, ex, rdy, clr, !m_valid);
            if (trunc) begin
                m_fe++;
            end else if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1'b1;
                if (clr) m_ovr = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
            chk($sformatf("rnd%0d_data", it),  rx_if.RxData,  m_data);
            chk($sformatf("rnd%0d_valid", it), rx_if.RxValid, m_valid);
            chk($sformatf("rnd%0d_ovr", it),   Overrun,       m_ovr);
            chk($sformatf("rnd%0d_fe", it),    fe_cnt,        m_fe);
            if (m_valid && $urandom_range(0, 1) == 1) begin
                pulse_read();
                m_valid = 1'b0;
                chk($sformatf("rnd%0d_valid_after_read", it), rx_if.RxValid, 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                pulse_clr();
                m_ovr = 1'b0;
                chk($sformatf("rnd%0d_ovr_after_clr", it), Overrun, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
